// File: rtl/weight_fetch_sched.sv
// weight_fetch_sched: sequences kernel fetches from a weight ROM, filter-major then channel-minor.
// The WEIGHT_FETCH_SCHED_TIMEOUT_EN macro adds a WAIT watchdog and the timeout_err output.
module weight_fetch_sched #(
    parameter int NUM_FILTERS    = 3,
    parameter int INPUT_CHANNELS = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int FW = NUM_FILTERS > 1 ? $clog2(NUM_FILTERS) : 1,
    localparam int CW = INPUT_CHANNELS > 1 ? $clog2(INPUT_CHANNELS) : 1,
    localparam int KW = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] rom_filter_idx,
    output logic [CW-1:0] rom_channel_idx,
    output logic          rom_read_enable,
    input  logic [KW-1:0] rom_weight,
    input  logic          rom_weight_valid,
    output logic [KW-1:0] out_weight,
    output logic [FW-1:0] out_filter_idx,
    output logic [CW-1:0] out_channel_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last_channel,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef WEIGHT_FETCH_SCHED_TIMEOUT_EN
    ,output logic         timeout_err
`endif
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] filt_q, filt_d, out_filt_q, out_filt_d;
    logic [CW-1:0] chan_q, chan_d, out_chan_q, out_chan_d;
    logic [KW-1:0] out_weight_q, out_weight_d;
    logic          out_lc_q, out_lc_d, out_l_q, out_l_d;
    logic          chan_last, last_pair, xfer, cap, timeout_hit;

    assign chan_last = chan_q == CW'(INPUT_CHANNELS - 1);
    assign last_pair = chan_last && filt_q == FW'(NUM_FILTERS - 1);
    assign xfer      = state_q == HOLD && out_ready && !abort;
    assign cap       = state_q == WAIT && rom_weight_valid && !abort;

`ifdef WEIGHT_FETCH_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          to_q, to_d;
    assign timeout_hit = state_q == WAIT && !rom_weight_valid && wd_q == TW'(TIMEOUT_CYCLES - 1);
    assign wd_d        = state_q == WAIT ? wd_q + 1'b1 : '0;
    assign to_d        = timeout_hit && !abort;
    assign timeout_err = to_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            filt_q       <= '0;
            chan_q       <= '0;
            out_weight_q <= '0;
            out_filt_q   <= '0;
            out_chan_q   <= '0;
            out_lc_q     <= 1'b0;
            out_l_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            filt_q       <= filt_d;
            chan_q       <= chan_d;
            out_weight_q <= out_weight_d;
            out_filt_q   <= out_filt_d;
            out_chan_q   <= out_chan_d;
            out_lc_q     <= out_lc_d;
            out_l_q      <= out_l_d;
        end
    end

    // abort outranks every other transition, including start and the handshake
    always_comb begin
        state_d = state_q;
        if (abort) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = start ? ISSUE : IDLE;
                ISSUE:   state_d = WAIT;
                WAIT:    state_d = rom_weight_valid ? HOLD : timeout_hit ? IDLE : WAIT;
                HOLD:    state_d = !out_ready ? HOLD : last_pair ? DONE : ISSUE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        filt_d       = filt_q;
        chan_d       = chan_q;
        if (abort || (state_q == IDLE && start)) begin
            filt_d = '0;
            chan_d = '0;
        end else if (xfer) begin
            chan_d = chan_last ? '0 : chan_q + 1'b1;
            filt_d = last_pair ? '0 : chan_last ? filt_q + 1'b1 : filt_q;
        end
        out_weight_d = cap ? rom_weight : out_weight_q;
        out_filt_d   = cap ? filt_q : out_filt_q;
        out_chan_d   = cap ? chan_q : out_chan_q;
        out_lc_d     = cap ? chan_last : out_lc_q;
        out_l_d      = cap ? last_pair : out_l_q;
    end

    always_comb begin
        rom_read_enable  = state_q == ISSUE;
        out_valid        = state_q == HOLD;
        busy             = state_q != IDLE;
        done             = state_q == DONE;
        rom_filter_idx   = filt_q;
        rom_channel_idx  = chan_q;
        out_weight       = out_weight_q;
        out_filter_idx   = out_filt_q;
        out_channel_idx  = out_chan_q;
        out_last_channel = out_lc_q;
        out_last         = out_l_q;
    end

endmodule

// File: tb/tb_weight_fetch_sched.sv
// tb_weight_fetch_sched: table-driven sweeps with a ROM model and scoreboard, plus abort/reset/timeout sequences.
module tb_weight_fetch_sched;

    localparam int KW = 144;

    logic          clk, rst_n, start, abort;
    logic [1:0]    rom_filter_idx, rom_channel_idx, out_filter_idx, out_channel_idx;
    logic          rom_read_enable, rom_weight_valid, out_valid, out_ready;
    logic [KW-1:0] rom_weight, out_weight;
    logic          out_last_channel, out_last, busy, done;
`ifdef WEIGHT_FETCH_SCHED_TIMEOUT_EN
    logic          timeout_err;
`endif

    weight_fetch_sched #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rom_filter_idx(rom_filter_idx), .rom_channel_idx(rom_channel_idx),
        .rom_read_enable(rom_read_enable), .rom_weight(rom_weight),
        .rom_weight_valid(rom_weight_valid), .out_weight(out_weight),
        .out_filter_idx(out_filter_idx), .out_channel_idx(out_channel_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last_channel(out_last_channel), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef WEIGHT_FETCH_SCHED_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef struct { int hold; int lat; int f; int c; bit lc; bit l; } vec_t;
    typedef struct { logic [KW-1:0] w; int f; int c; bit lc; bit l; } exp_t;

    vec_t vec[9];
    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   rre_cnt = 0, done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_read_enable) rre_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] wfun(input int f, input int c, input int s);
        logic [KW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'(f * 256 + c * 16 + k + s * 4096);
        return w;
    endfunction

    task automatic wait_rre(output int n);
        n = 0;
        while (!rom_read_enable && n < 20) begin
            step;
            n++;
        end
        if (!rom_read_enable) chk("rre_wait_expired", 0, 1);
    endtask

    task automatic do_xfer(input int i, input int salt, input bit first);
        int   n;
        exp_t e;
        wait_rre(n);
        if (!first) chk("issue_gap", n, 0);
        chk("rom_filter_idx", rom_filter_idx, vec[i].f);
        chk("rom_channel_idx", rom_channel_idx, vec[i].c);
        step;
        chk("rre_width", rom_read_enable, 0);
        repeat (vec[i].lat) step;
        rom_weight = wfun(rom_filter_idx, rom_channel_idx, salt);
        rom_weight_valid = 1'b1;
        sb.push_back('{wfun(vec[i].f, vec[i].c, salt), vec[i].f, vec[i].c, vec[i].lc, vec[i].l});
        step;
        rom_weight_valid = 1'b0;
        rom_weight = '1;
        chk("hold_valid", out_valid, 1);
        repeat (vec[i].hold) begin
            step;
            chk("stall_valid", out_valid, 1);
            chk("stall_weight", out_weight, sb[0].w);
            chk("stall_no_rre", rom_read_enable, 0);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        chk("out_filter_idx", out_filter_idx, e.f);
        chk("out_channel_idx", out_channel_idx, e.c);
        chk("out_weight", out_weight, e.w);
        chk("out_last_channel", out_last_channel, e.lc);
        chk("out_last", out_last, e.l);
        chk("no_done_midsweep", done, 0);
        step;
        out_ready = 1'b0;
    endtask

    task automatic run_sweep(input int salt);
        int r0, d0;
        r0 = rre_cnt;
        d0 = done_cnt;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 9; i++) do_xfer(i, salt, i == 0);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        step;
        chk("done_cleared", done, 0);
        chk("busy_after", busy, 0);
        step;
        chk("rre_count", rre_cnt - r0, 9);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int n, d0;
        for (int i = 0; i < 9; i++) begin
            vec[i].f    = i / 3;
            vec[i].c    = i % 3;
            vec[i].lc   = (i % 3) == 2;
            vec[i].l    = i == 8;
            vec[i].lat  = (i * 7) % 4;
            vec[i].hold = 0;
        end
        vec[3].hold = 5;
        vec[5].hold = 2;
        vec[8].hold = 1;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        out_ready = 1'b0; rom_weight_valid = 1'b0; rom_weight = '0;
        step;
        step;
        chk("rst_busy", busy, 0);
        chk("rst_out_weight", out_weight, 0);
        chk("rst_rre", rom_read_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        step;

        run_sweep(1);

        // abort while waiting on (1,1)
        d0 = done_cnt;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 4; i++) do_xfer(i, 2, i == 0);
        wait_rre(n);
        chk("abort_rom_f", rom_filter_idx, 1);
        chk("abort_rom_c", rom_channel_idx, 1);
        step;
        abort = 1'b1;
        start = 1'b1;
        step;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_rre", rom_read_enable, 0);
        repeat (3) step;
        chk("abort_no_done", done_cnt - d0, 0);
        rom_weight = wfun(3, 3, 9);
        rom_weight_valid = 1'b1;
        step;
        rom_weight_valid = 1'b0;
        step;
        chk("stray_no_capture", out_weight, wfun(1, 0, 2));
        chk("stray_out_valid", out_valid, 0);
        chk("stray_busy", busy, 0);
        run_sweep(3);

        // reset while holding (0,0)
        start = 1'b1;
        step;
        start = 1'b0;
        wait_rre(n);
        step;
        rom_weight = wfun(0, 0, 4);
        rom_weight_valid = 1'b1;
        step;
        rom_weight_valid = 1'b0;
        chk("pre_rst_hold", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_weight", out_weight, 0);
        chk("mid_rst_idx", {out_filter_idx, out_channel_idx, rom_filter_idx, rom_channel_idx}, 0);
        chk("mid_rst_flags", {out_last_channel, out_last, done, rom_read_enable}, 0);
        step;
        rst_n = 1'b1;
        step;
        run_sweep(5);

`ifdef WEIGHT_FETCH_SCHED_TIMEOUT_EN
        d0 = done_cnt;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("to_issue", rom_read_enable, 1);
        repeat (8) step;
        chk("to_not_yet", timeout_err, 0);
        chk("to_busy_wait", busy, 1);
        step;
        chk("to_pulse", timeout_err, 1);
        chk("to_busy_low", busy, 0);
        step;
        chk("to_pulse_end", timeout_err, 0);
        chk("to_no_done", done_cnt - d0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
